wavetable_voice_gen: RTL and testbench

WAVETABLE_VOICE_GEN -- requirements
Module: wavetable_voice_gen

---
 rtl/wavetable_voice_gen.sv | 185 ++++++++++++++++++
 tb/tb_wavetable_voice_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavetable_voice_gen.sv
// Time-multiplexed wavetable voice generator: one voice per cycle is looked up,
// scaled by its envelope level and summed into a saturated sample per frame.
module wavetable_voice_gen #(
  parameter int NUM_VOICES   = 4,
  parameter int TBL_AW       = 6,
  parameter int PHASE_W      = 24,
  parameter int OUT_W        = 16,
  parameter int NUM_TIMBRES  = 2,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8,
  localparam int VW = $clog2(NUM_VOICES),
  localparam int TW = (NUM_TIMBRES > 1) ? $clog2(NUM_TIMBRES) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sample_tick,
  input  logic               i_cfg_valid,
  input  logic [VW-1:0]      i_cfg_voice,
  input  logic [PHASE_W-1:0] i_cfg_phase_inc,
  input  logic [TW-1:0]      i_cfg_timbre,
  input  logic               i_cfg_gate,
  input  logic               i_tbl_we,
  input  logic [TW-1:0]      i_tbl_sel,
  input  logic [TBL_AW-1:0]  i_tbl_addr,
  input  logic [OUT_W-1:0]   i_tbl_data,
  output logic               o_cfg_ready,
  output logic [OUT_W-1:0]   o_sample,
  output logic               o_sample_valid,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int SUM_W     = OUT_W + VW;
  localparam int PROD_W    = OUT_W + 9;
  localparam int TBL_DEPTH = 2 ** (TW + TBL_AW);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(VW + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(VW + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  // state | meaning
  // IDLE  | waiting for a sample tick, config and table writes accepted
  // RUN   | issuing one voice lookup per cycle
  // DRAIN | last voice travelling through the multiply/accumulate pipeline
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PHASE_W-1:0] r_phase  [NUM_VOICES];
  logic [PHASE_W-1:0] r_inc    [NUM_VOICES];
  logic [7:0]         r_level  [NUM_VOICES];
  logic               r_gate   [NUM_VOICES];
  logic [TW-1:0]      r_timbre [NUM_VOICES];
  logic [VW-1:0]      r_voice;

  logic [OUT_W-1:0]   r_tbl [TBL_DEPTH];
  logic [OUT_W-1:0]   r_p1_word;
  logic [7:0]         r_p1_level;
  logic               r_p1_vld;
  logic               r_p1_last;
  logic signed [SUM_W-1:0] r_p2_prod;
  logic               r_p2_vld;
  logic               r_p2_last;
  logic signed [SUM_W-1:0] r_acc;

  logic               w_busy;
  logic               w_run;
  logic               w_cfg_acc;
  logic               w_tbl_acc;
  logic               w_last_voice;
  logic [8:0]         w_lvl_up;
  logic [7:0]         w_level_nxt;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0]  w_sum;
  logic [OUT_W-1:0]   w_sat;

  assign w_busy       = (r_state != S_IDLE);
  assign w_run        = (r_state == S_RUN);
  assign o_busy       = w_busy;
  assign o_cfg_ready  = !w_busy;
  assign w_cfg_acc    = i_cfg_valid && !w_busy;
  assign w_tbl_acc    = i_tbl_we && !w_busy;
  assign w_last_voice = (r_voice == VW'(NUM_VOICES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_sample_tick) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_voice) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_p2_vld && r_p2_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_lvl_up = {1'b0, r_level[r_voice]} + 9'(ATTACK_STEP);
    if (r_gate[r_voice])
      w_level_nxt = (w_lvl_up > 9'd255) ? 8'hFF : w_lvl_up[7:0];
    else if (r_level[r_voice] < 8'(RELEASE_STEP))
      w_level_nxt = '0;
    else
      w_level_nxt = r_level[r_voice] - 8'(RELEASE_STEP);
  end

  // Config writes only happen in IDLE and voice updates only in RUN, so they never collide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_phase[v]  <= '0;
        r_inc[v]    <= '0;
        r_level[v]  <= '0;
        r_gate[v]   <= 1'b0;
        r_timbre[v] <= '0;
      end
      r_voice <= '0;
    end else begin
      if (w_cfg_acc) begin
        r_inc[i_cfg_voice]    <= i_cfg_phase_inc;
        r_timbre[i_cfg_voice] <= i_cfg_timbre;
        r_gate[i_cfg_voice]   <= i_cfg_gate;
        if (i_cfg_gate && !r_gate[i_cfg_voice]) r_phase[i_cfg_voice] <= '0;
      end
      if (w_run) begin
        r_phase[r_voice] <= r_phase[r_voice] + r_inc[r_voice];
        r_level[r_voice] <= w_level_nxt;
        r_voice          <= r_voice + 1'b1;
      end else begin
        r_voice <= '0;
      end
    end
  end

  // Wavetable storage keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (w_tbl_acc) r_tbl[{i_tbl_sel, i_tbl_addr}] <= i_tbl_data;
    if (w_run) r_p1_word <= r_tbl[{r_timbre[r_voice], r_phase[r_voice][PHASE_W-1 -: TBL_AW]}];
  end

  assign w_prod = PROD_W'($signed(r_p1_word)) * PROD_W'($signed({1'b0, r_p1_level}));
  assign w_sum  = r_acc + r_p2_prod;

  always_comb begin
    if (w_sum > SAT_MAX)      w_sat = SAT_MAX[OUT_W-1:0];
    else if (w_sum < SAT_MIN) w_sat = SAT_MIN[OUT_W-1:0];
    else                      w_sat = w_sum[OUT_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p1_vld       <= 1'b0;
      r_p1_last      <= 1'b0;
      r_p1_level     <= '0;
      r_p2_vld       <= 1'b0;
      r_p2_last      <= 1'b0;
      r_p2_prod      <= '0;
      r_acc          <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      r_p1_vld       <= w_run;
      r_p1_last      <= w_run && w_last_voice;
      r_p1_level     <= r_level[r_voice];
      r_p2_vld       <= r_p1_vld;
      r_p2_last      <= r_p1_last;
      r_p2_prod      <= SUM_W'(w_prod >>> 8);
      o_sample_valid <= 1'b0;
      if (r_p2_vld) begin
        if (r_p2_last) begin
          o_sample       <= w_sat;
          o_sample_valid <= 1'b1;
          r_acc          <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
      if (i_sample_tick && w_busy) o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wavetable_voice_gen.sv
// Bench for wavetable_voice_gen: directed envelope/wrap/saturation cases plus
// randomized config and table traffic, checked against a frame-level model.
module tb_wavetable_voice_gen;
  localparam int NV = 4;
  localparam int AW = 6;
  localparam int PW = 24;
  localparam int OW = 16;
  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          cfg_valid;
  logic [1:0]    cfg_voice;
  logic [PW-1:0] cfg_phase_inc;
  logic [0:0]    cfg_timbre;
  logic          cfg_gate;
  logic          tbl_we;
  logic [0:0]    tbl_sel;
  logic [AW-1:0] tbl_addr;
  logic [OW-1:0] tbl_data;
  logic          cfg_ready;
  logic [OW-1:0] sample;
  logic          sample_valid;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  wavetable_voice_gen #(
    .NUM_VOICES(NV), .TBL_AW(AW), .PHASE_W(PW), .OUT_W(OW), .NUM_TIMBRES(NT),
    .ATTACK_STEP(16), .RELEASE_STEP(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_tick(tick),
    .i_cfg_valid(cfg_valid), .i_cfg_voice(cfg_voice), .i_cfg_phase_inc(cfg_phase_inc),
    .i_cfg_timbre(cfg_timbre), .i_cfg_gate(cfg_gate),
    .i_tbl_we(tbl_we), .i_tbl_sel(tbl_sel), .i_tbl_addr(tbl_addr), .i_tbl_data(tbl_data),
    .o_cfg_ready(cfg_ready), .o_sample(sample), .o_sample_valid(sample_valid),
    .o_busy(busy), .o_overrun(overrun)
  );

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] last_smp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-voice state as plain integers, one call per frame.
  int      m_phase  [NV];
  int      m_inc    [NV];
  int      m_level  [NV];
  bit      m_gate   [NV];
  int      m_timbre [NV];
  shortint m_tbl    [NT][64];

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = 0; m_inc[v] = 0; m_level[v] = 0; m_gate[v] = 0; m_timbre[v] = 0;
    end
  endtask

  task automatic model_cfg(input int v, input int inc, input int t, input bit g);
    if (g && !m_gate[v]) m_phase[v] = 0;
    m_inc[v] = inc; m_timbre[v] = t; m_gate[v] = g;
  endtask

  task automatic model_frame(output logic [OW-1:0] exp);
    int sum;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      int idx;
      int word;
      idx  = m_phase[v] / (1 << (PW - AW));
      word = m_tbl[m_timbre[v]][idx];
      sum += (word * m_level[v]) >>> 8;
      m_phase[v] = (m_phase[v] + m_inc[v]) % (1 << PW);
      if (m_gate[v]) m_level[v] = (m_level[v] + 16 > 255) ? 255 : m_level[v] + 16;
      else           m_level[v] = (m_level[v] < 8) ? 0 : m_level[v] - 8;
    end
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    exp = sum[OW-1:0];
  endtask

  task automatic tbl_write(input int s, input int a, input logic [OW-1:0] d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_sel = 1'(s); tbl_addr = AW'(a); tbl_data = d;
    @(negedge clk);
    tbl_we = 1'b0;
    m_tbl[s][a] = shortint'(d);
  endtask

  task automatic cfg_write(input int v, input int inc, input int t, input bit g);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_voice = 2'(v); cfg_phase_inc = PW'(inc); cfg_timbre = 1'(t); cfg_gate = g;
    @(negedge clk);
    cfg_valid = 1'b0;
    model_cfg(v, inc, t, g);
  endtask

  task automatic do_frame(input bit with_cfg, input int v, input int inc, input int t, input bit g);
    logic [OW-1:0] exp;
    int lat;
    @(negedge clk);
    tick = 1'b1;
    if (with_cfg) begin
      cfg_valid = 1'b1; cfg_voice = 2'(v); cfg_phase_inc = PW'(inc); cfg_timbre = 1'(t); cfg_gate = g;
    end
    @(posedge clk);
    #1;
    tick = 1'b0; cfg_valid = 1'b0;
    if (with_cfg) model_cfg(v, inc, t, g);
    model_frame(exp);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_in_frame", {31'd0, busy}, 32'd1);
      if (sample_valid) begin
        lat = n;
        break;
      end
    end
    check("valid_latency", lat, 7);
    check("sample", {16'd0, sample}, {16'd0, exp});
    last_smp = sample;
  endtask

  task automatic frame();
    do_frame(1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    logic [OW-1:0] exp;
    int lat;
    int pulses;
    int idx;
    rst = 1'b1; tick = 1'b0; cfg_valid = 1'b0; cfg_voice = '0; cfg_phase_inc = '0;
    cfg_timbre = '0; cfg_gate = 1'b0; tbl_we = 1'b0; tbl_sel = '0; tbl_addr = '0; tbl_data = '0;
    last_smp = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_sample", {16'd0, sample}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;

    for (int a = 0; a < 64; a++) begin
      tbl_write(0, a, 16'h1000);
      tbl_write(1, a, 16'($urandom));
    end

    // Attack from level 0 on a constant table
    cfg_write(0, 24'h040000, 0, 1'b1);
    frame(); check("attack_f0", {16'd0, last_smp}, 32'h0000);
    frame(); check("attack_f1", {16'd0, last_smp}, 32'h0100);
    frame(); check("attack_f2", {16'd0, last_smp}, 32'h0200);

    // Ramp table, index sweeps and wraps past 64 frames
    for (int a = 0; a < 64; a++) tbl_write(0, a, 16'(a));
    for (int f = 0; f < 80; f++) frame();

    // Tick, cfg and table write while busy are all dropped
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    model_frame(exp);
    @(negedge clk);
    check("busy_run", {31'd0, busy}, 32'd1);
    check("ready_run", {31'd0, cfg_ready}, 32'd0);
    idx = m_phase[0] / (1 << (PW - AW));
    tick = 1'b1; cfg_valid = 1'b1; cfg_voice = 2'd0; cfg_phase_inc = 24'h100000;
    cfg_timbre = 1'b1; cfg_gate = 1'b0;
    tbl_we = 1'b1; tbl_sel = 1'b0; tbl_addr = AW'(idx); tbl_data = 16'h7777;
    @(negedge clk);
    tick = 1'b0; cfg_valid = 1'b0; tbl_we = 1'b0;
    lat = 0;
    for (int n = 3; n <= 20; n++) begin
      @(negedge clk);
      if (sample_valid) begin
        lat = n;
        break;
      end
    end
    check("ovr_latency", lat, 7);
    check("ovr_sample", {16'd0, sample}, {16'd0, exp});
    check("overrun_set", {31'd0, overrun}, 32'd1);
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    check("no_extra_frame", pulses, 0);
    frame();
    frame();
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Release to zero, then re-gate restarts phase
    cfg_write(0, 24'h040000, 0, 1'b0);
    for (int f = 0; f < 36; f++) frame();
    check("release_floor", {16'd0, last_smp}, 32'd0);
    cfg_write(0, 24'h0C0000, 0, 1'b1);
    for (int f = 0; f < 20; f++) frame();

    // Saturation, both rails
    for (int a = 0; a < 64; a++) tbl_write(0, a, 16'h7FFF);
    for (int v = 0; v < NV; v++) cfg_write(v, 24'h040000, 0, 1'b1);
    for (int f = 0; f < 17; f++) frame();
    check("sat_pos", {16'd0, last_smp}, 32'h7FFF);
    for (int a = 0; a < 64; a++) tbl_write(0, a, 16'h8000);
    frame();
    check("sat_neg", {16'd0, last_smp}, 32'h8000);

    // Randomized traffic, including cfg in the same cycle as the tick
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        tbl_write(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 16'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        cfg_write(int'($urandom_range(0, 3)), int'($urandom & 32'hFFFFFF),
                  int'($urandom_range(0, 1)), 1'($urandom));
      do_frame(1'($urandom), int'($urandom_range(0, 3)), int'($urandom & 32'hFFFFFF),
               int'($urandom_range(0, 1)), 1'($urandom));
    end

    // Reset in the middle of a frame
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, cfg_ready}, 32'd1);
    check("midrst_valid", {31'd0, sample_valid}, 32'd0);
    check("midrst_sample", {16'd0, sample}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    check("aborted_frame", pulses, 0);

    // Tables survive reset
    cfg_write(0, int'($urandom & 32'hFFFFFF), 1, 1'b1);
    cfg_write(2, int'($urandom & 32'hFFFFFF), 0, 1'b1);
    for (int f = 0; f < 20; f++) frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
